// File: rtl/debounce_pkg.sv
// Shared definitions for the button toggle debouncer: FSM state encoding,
// default configuration constants and a counter-width helper.
package debounce_pkg;

    localparam int unsigned DEBOUNCE_STABLE_CYCLES_DEF = 16;
    localparam int unsigned DEBOUNCE_SYNC_STAGES_DEF   = 2;

    // Debounce FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        HELD        = 2'd2,
        ARM_RELEASE = 2'd3
    } debounce_state_e;

    // Stability counter width; never below one bit so the counter is always declarable.
    function automatic int unsigned debounce_cnt_width(input int unsigned stable_cycles);
        return (stable_cycles > 32'd1) ? 32'($clog2(stable_cycles)) : 32'd1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-stage flop synchronizer for a single asynchronous input.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, clears every stage to 0
//   d      : asynchronous input
//   q      : synchronized output (last stage)
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input in at bit 0; bit STAGES-1 is the settled sample.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_toggle_debouncer.sv
// Turns a raw bouncing push-button into a clean one-cycle toggle strobe and a
// debounced level, suitable for driving a toggle flip-flop directly.
//   clk     : single clock, rising edge
//   _reset  : asynchronous active-low reset
//   btn_raw : raw button input, asynchronous, active-high
//   t       : one-cycle toggle strobe per accepted press (registered)
//   level   : debounced button state (registered)
//   busy    : high while a press or release is being qualified (registered)
// Build option: define DEBOUNCE_RELEASE_STROBE_EN to also pulse t when a
// release is accepted (coincident with level falling).
module button_toggle_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES   = DEBOUNCE_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic _reset,
    input  logic btn_raw,
    output logic t,
    output logic level,
    output logic busy
);

    localparam int unsigned    CNT_W    = debounce_cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 32'd1);

    logic            btn_s;

    debounce_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            strobe_q, strobe_d;
    logic            t_q, t_d;
    logic            level_q, level_d;
    logic            busy_q, busy_d;

    // Bring the asynchronous button into the clk domain.
    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk   (clk),
        .rst_n (_reset),
        .d     (btn_raw),
        .q     (btn_s)
    );

    // Next-state, counter and output decode. The counter restarts at 0 on
    // every transition and saturates at CNT_LAST by construction.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = ARM_PRESS;
                    cnt_d   = '0;
                end
            end
            ARM_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = HELD;
                    cnt_d    = '0;
                    strobe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = ARM_RELEASE;
                    cnt_d   = '0;
                end
            end
            ARM_RELEASE: begin
                if (btn_s) begin
                    // Release bounce: fall back to HELD without a strobe.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef DEBOUNCE_RELEASE_STROBE_EN
                    strobe_d = 1'b1;
`else
                    strobe_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the state one cycle later so t lines up with level.
        t_d     = strobe_q;
        level_d = (state_q == HELD) || (state_q == ARM_RELEASE);
        busy_d  = (state_q == ARM_PRESS) || (state_q == ARM_RELEASE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            t_q      <= 1'b0;
            level_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            t_q      <= t_d;
            level_q  <= level_d;
            busy_q   <= busy_d;
        end
    end

    assign t     = t_q;
    assign level = level_q;
    assign busy  = busy_q;

endmodule

// File: doc/button_toggle_debouncer.md
# button_toggle_debouncer

- Conditions a raw, bouncing push-button input into a clean one-cycle toggle strobe `t` and a debounced level `level`.
- Sits directly upstream of the lab toggle flip-flop: `t` drives its toggle input on the same `clk` and `_reset`, so each physical press flips the stored bit exactly once.
- Contains a synchronizer, a stability counter and a four-state FSM.

## Interface
Parameters:
- `STABLE_CYCLES`, default 16: consecutive synchronized samples required to accept a change; legal range ≥ 2.
- `SYNC_STAGES`, default 2: synchronizer depth; legal range ≥ 2.

Ports:
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `_reset`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  1  raw button, asynchronous to `clk`, active-high.
- `t`  out  1  one-cycle toggle strobe, registered.
- `level`  out  1  debounced button state, registered.
- `busy`  out  1  high while a change is being qualified.

## Operation
- Synchronizer: a `SYNC_STAGES`-deep flop chain on `btn_raw`. Every stage resets to 0. The output of the last stage is `btn_s`.
- Stability counter `cnt`: width `$clog2(STABLE_CYCLES)`. It clears on every state entry and never wraps.
- FSM states:
  - IDLE: `level`=0. `btn_s`=1 → ARM_PRESS.
  - ARM_PRESS: `level`=0.
    - `btn_s`=0 → IDLE.
    - `btn_s`=1 and `cnt`==`STABLE_CYCLES`-1 → HELD; assert `t` next cycle.
    - Otherwise `cnt`++.
  - HELD: `level`=1. `btn_s`=0 → ARM_RELEASE.
  - ARM_RELEASE: `level`=1.
    - `btn_s`=1 → HELD, with no strobe.
    - `btn_s`=0 and `cnt`==`STABLE_CYCLES`-1 → IDLE.
    - Otherwise `cnt`++.
- `t` is high for exactly one cycle per accepted press. It is never high on two consecutive cycles.
- `busy` = state is ARM_PRESS or ARM_RELEASE.
- Bounces shorter than the qualification window are absorbed. A low sample in ARM_PRESS restarts qualification from IDLE. A high sample in ARM_RELEASE returns to HELD.
- Reset: asserting `_reset` forces all synchronizer stages, `cnt`, the FSM (to IDLE), `t`, `level` and `busy` to 0 immediately, regardless of `clk`. This includes mid-qualification. After release, a held button must requalify the full window.

## Timing
- Let edge k be the first edge at which `btn_s` is sampled 1 in IDLE.
  - Entry into ARM_PRESS occurs at k+1.
  - `t` and `level` rise at edge k+`STABLE_CYCLES`+1, provided `btn_s` is 1 on every sample from k through k+`STABLE_CYCLES`.
- End-to-end latency from a clean `btn_raw` rise to `t` is `SYNC_STAGES`+`STABLE_CYCLES`+1 edges. With defaults this is 19 edges.
- Release latency to `level` falling is symmetric. The release path never produces `t` unless the configuration macro below is defined.
- Because `t` is registered and glitch-free, it may feed the downstream toggle input directly.

## Configuration
- Macro: `DEBOUNCE_RELEASE_STROBE_EN`.
- Defined: the ARM_RELEASE → IDLE transition also pulses `t` for one cycle, coincident with `level` falling. Each press/release pair then produces two strobes.
- Undefined: the release path is silent. `t` fires only on press acceptance.

## Structure
- Shared package `debounce_pkg` holds:
  - the FSM state enum (IDLE, ARM_PRESS, HELD, ARM_RELEASE), 2-bit encoding;
  - the default constants `DEBOUNCE_STABLE_CYCLES_DEF`=16 and `DEBOUNCE_SYNC_STAGES_DEF`=2.
- One sub-module: `sync_chain`, the parameterized `SYNC_STAGES` flop synchronizer with async active-low reset.
- Counter and FSM live in the top module.

## Test plan
All scenarios use `STABLE_CYCLES`=4, `SYNC_STAGES`=2.
1. Clean press: `btn_raw` rises before edge 0 and is held 20 cycles.
   - Exactly one `t` pulse, high during edge 7 → 8.
   - `level` high from edge 7.
   - `busy` high for edges 3–6.
2. Press bounce: 5 bursts of 2 cycles high / 1 cycle low, then steady high.
   - No `t` and no `level` during the bursts.
   - A single `t` 7 edges after the final steady rise.
3. Release bounce while HELD: 1-cycle-low glitches spaced 3 cycles apart.
   - `level` stays 1; no `t`.
   - A final steady low drops `level` after 7 edges.
4. Reset mid-qualification: `_reset` asserted while in ARM_PRESS (`cnt`=2), with `btn_raw` held high.
   - `t`, `level` and `busy` go 0 immediately.
   - After deassertion, `t` arrives a full 7 edges later.
5. Single-cycle glitch: `btn_raw` high for 1 cycle.
   - `busy` high for one cycle.
   - `t` and `level` never assert.
6. With `DEBOUNCE_RELEASE_STROBE_EN` defined: clean press then clean release.
   - Exactly two `t` pulses.
   - The second pulse is coincident with `level` falling.
